hilo_muldiv_ctrl: RTL
=====================

# hilo_muldiv_ctrl

Iterative multiply/divide sequencer that owns the HI/LO register pair of the MIPS core. It sits beside the single-cycle ALU in the execute stage. It accepts MULT/MULTU/DIV/DIVU issues from the control unit and runs a 32-iteration shift-add or restoring-divide datapath. While a result is pending it raises a structural-hazard stall toward fetch for any instruction that touches HI/LO.

## Interface
- `WIDTH`, 32: operand width; HI and LO are each `WIDTH` bits.
- `ITER`, `WIDTH`: iteration count, fixed equal to `WIDTH`.

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset; asynchronous, active-high.
- `start` in 1: issue a mul/div op this cycle.
- `op` in 2: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- `a`, `b` in `WIDTH`: rs and rt operands; sampled only on the accepting edge.
- `mt_we` in 1: MTHI/MTLO write request.
- `mt_sel` in 1: 0 selects LO, 1 selects HI.
- `mt_data` in `WIDTH`: data for MTHI/MTLO.
- `rd_req` in 1: MFHI/MFLO issued this cycle.
- `hi`, `lo` out `WIDTH`: architectural HI/LO (registered).
- `busy` out 1: operation in flight.
- `stall` out 1: hold fetch/execute this cycle.
- `done` out 1: one-cycle pulse when a result commits.
- `div_by_zero` out 1: set with `done` when a DIV/DIVU has `b`==0; held until the next accepted `start`.

## Operation
- FSM states:
  - IDLE → RUN on `start`.
  - RUN → FIXUP after `ITER` iterations.
  - FIXUP → IDLE.
- Accept: in IDLE with `start`=1, latch `op`, |a|, |b| and the sign bits. Magnitudes are taken only for signed ops. Clear the iteration counter and `div_by_zero`.
- Multiply (RUN): 2·`WIDTH` product register, shift-add of one multiplier bit per cycle.
- Divide (RUN): restoring division. Remainder register is `WIDTH`+1 bits; one quotient bit per cycle.
- FIXUP, signed multiply: negate the 64-bit product if the operand signs differ.
- FIXUP, signed divide:
  - Negate the quotient if the signs differ.
  - The remainder takes the dividend's sign.
  - 0x80000000 / -1 yields LO=0x80000000, HI=0.
- FIXUP commit: HI←upper/remainder, LO←lower/quotient.
- Divide by zero:
  - Runs at full latency.
  - Unsigned result: LO=0xFFFFFFFF, HI=a.
  - Signed: sign fixup is skipped; LO=0xFFFFFFFF, HI=original signed a.
  - `div_by_zero`=1.
- MTHI/MTLO: in IDLE, `mt_we` writes the selected register on the next edge.
- `start` and `mt_we` in the same IDLE cycle: `start` wins and the MT write is dropped. The control unit guarantees exclusivity.
- `rd_req` in IDLE: no stall. The current `hi`/`lo` are valid combinationally for the reader.
- `stall` = `busy` & (`start` | `rd_req` | `mt_we`), combinational.
  - A stalled requester holds its inputs until `stall` drops.
  - `start` while busy is ignored (not queued).
- `rst` at any time:
  - State → IDLE; counter=0.
  - `hi`=`lo`=0; `busy`=`done`=`div_by_zero`=0.
  - Any in-flight operation is discarded.

## Timing
- The accepting edge is E0.
- RUN iterations occur on E1..E32.
- FIXUP commits HI/LO on E33. `done` is high for the single cycle after E33.
- Total: 34 cycles from `start` to result visible. Back-to-back issue is possible the cycle `done` is high.
- `busy` = (state ≠ IDLE), high from after E0 until E33.
- A stalled MFHI/MFLO is released in the `done` cycle and reads the new value.
- MT writes are visible on `hi`/`lo` one cycle after the request.
- All outputs are registered except `stall`.

## Structure
- Add to `cpu_pkg`:
  - `muldiv_op_t` enum (MULT, MULTU, DIV, DIVU).
  - `muldiv_state_t` (IDLE, RUN, FIXUP).
  - `MULDIV_ITER` = 32.
- One sub-module is natural: `muldiv_step`, combinational. It computes one shift-add or restore-subtract iteration from the current accumulators and `op`. The FSM, counter, sign fixup and HI/LO ownership stay in `hilo_muldiv_ctrl`.

## Test plan
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF → after 34 cycles HI=0xFFFFFFFE, LO=0x00000001; `done` high exactly one cycle; `busy` high 33 cycles.
- MULT a=0xFFFFFFFD (-3), b=7 → HI=0xFFFFFFFF, LO=0xFFFFFFEB (-21).
- DIV a=-7, b=2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU a=100, b=7 → LO=14, HI=2. DIV 0x80000000/-1 → LO=0x80000000, HI=0.
- DIVU a=5, b=0 → LO=0xFFFFFFFF, HI=5, `div_by_zero`=1 with `done`, cleared on the next `start`.
- Hazards and MT writes:
  - MFHI (`rd_req`) asserted 5 cycles after `start` → `stall`=1 until the `done` cycle, then 0.
  - `mt_we`/`mt_sel`=1/0x1234 in IDLE → `hi`=0x1234 next cycle, `lo` unchanged.
  - `start` while busy → ignored, `stall`=1.
- `rst` pulsed 10 cycles into RUN → immediately `busy`=0, `hi`=`lo`=0, no `done`. A following MULTU 6×7 → LO=42, HI=0 at normal latency.

Source files
------------

// File: rtl/hilo_muldiv_ctrl_pkg.sv
// hilo_muldiv_ctrl_pkg: shared types and constants for the HI/LO multiply/divide sequencer
package hilo_muldiv_ctrl_pkg;
  typedef enum logic [1:0] {MULT = 2'b00, MULTU = 2'b01, DIV = 2'b10, DIVU = 2'b11} muldiv_op_t;
  typedef enum logic [1:0] {IDLE, RUN, FIXUP} muldiv_state_t;
  localparam int MULDIV_ITER = 32;
  function automatic logic op_signed(muldiv_op_t o);
    return (o == MULT) || (o == DIV);
  endfunction
endpackage

// File: rtl/hilo_muldiv_ctrl_step.sv
// hilo_muldiv_ctrl_step: one shift-add multiply or restoring-divide iteration
module hilo_muldiv_ctrl_step #(
  parameter int WIDTH = 32
) (
  input  logic             div,
  input  logic [WIDTH-1:0] acc,
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] m,
  output logic [WIDTH-1:0] acc_nx,
  output logic [WIDTH-1:0] q_nx
);
  logic [WIDTH-1:0] addend;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   sh;
  logic [WIDTH+1:0] diff;
  // diff is two bits wider than the divisor so the borrow is unambiguous when sh uses its top bit
  always_comb begin
    addend = q[0] ? m : '0;
    sum    = {1'b0, acc} + {1'b0, addend};
    sh     = {acc, q[WIDTH-1]};
    diff   = {1'b0, sh} - {2'b00, m};
    acc_nx = div ? (diff[WIDTH+1] ? sh[WIDTH-1:0] : diff[WIDTH-1:0]) : sum[WIDTH:1];
    q_nx   = div ? {q[WIDTH-2:0], ~diff[WIDTH+1]} : {sum[0], q[WIDTH-1:1]};
  end
endmodule

// File: rtl/hilo_muldiv_ctrl.sv
// hilo_muldiv_ctrl: iterative mul/div sequencer owning HI/LO, with HI/LO hazard stall
module hilo_muldiv_ctrl
  import hilo_muldiv_ctrl_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int ITER  = WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             mt_we,
  input  logic             mt_sel,
  input  logic [WIDTH-1:0] mt_data,
  input  logic             rd_req,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             stall,
  output logic             done,
  output logic             div_by_zero
);
  localparam int CW = $clog2(ITER);
  muldiv_state_t state, state_nx;
  logic [CW-1:0] cnt;
  logic [WIDTH-1:0] acc, q, m, acc_nx, q_nx, a_mag, b_mag, hi_nx, lo_nx, quo, rem;
  logic [2*WIDTH-1:0] prod;
  logic div, sa, sb, bz, sa_in, sb_in, accept, last, mt_ok;
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state == IDLE ? (start ? RUN : IDLE) :
               state == RUN  ? (last ? FIXUP : RUN) : IDLE;
  end
  always_comb begin
    accept = (state == IDLE) && start;
    mt_ok  = (state == IDLE) && !start && mt_we;
    last   = cnt == CW'(ITER - 1);
    stall  = busy && (start || rd_req || mt_we);
  end
  // Magnitudes only for signed ops; the sign bits drive the fixup
  always_comb begin
    sa_in = op_signed(muldiv_op_t'(op)) && a[WIDTH-1];
    sb_in = op_signed(muldiv_op_t'(op)) && b[WIDTH-1];
    a_mag = sa_in ? -a : a;
    b_mag = sb_in ? -b : b;
  end
  hilo_muldiv_ctrl_step #(.WIDTH(WIDTH)) u_step (
    .div(div), .acc(acc), .q(q), .m(m), .acc_nx(acc_nx), .q_nx(q_nx)
  );
  // A zero divisor leaves all-ones quotient and |a| remainder; restoring a's sign returns original a
  always_comb begin
    prod  = (sa ^ sb) ? -{acc, q} : {acc, q};
    quo   = (sa ^ sb) ? -q : q;
    rem   = sa ? -acc : acc;
    hi_nx = div ? rem : prod[2*WIDTH-1:WIDTH];
    lo_nx = div ? (bz ? '1 : quo) : prod[WIDTH-1:0];
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cnt         <= '0;
      acc         <= '0;
      q           <= '0;
      m           <= '0;
      div         <= 1'b0;
      sa          <= 1'b0;
      sb          <= 1'b0;
      bz          <= 1'b0;
      hi          <= '0;
      lo          <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      busy <= state_nx != IDLE;
      done <= state == FIXUP;
      if (accept) begin
        cnt         <= '0;
        acc         <= '0;
        q           <= a_mag;
        m           <= b_mag;
        div         <= op[1];
        sa          <= sa_in;
        sb          <= sb_in;
        bz          <= b == '0;
        div_by_zero <= 1'b0;
      end else if (state == RUN) begin
        cnt <= cnt + 1'b1;
        acc <= acc_nx;
        q   <= q_nx;
      end else if (state == FIXUP) begin
        hi          <= hi_nx;
        lo          <= lo_nx;
        div_by_zero <= div && bz;
      end
      if (mt_ok && mt_sel) hi <= mt_data;
      if (mt_ok && !mt_sel) lo <= mt_data;
    end
endmodule
